// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX and RX sides: FSM state
// encoding and frame geometry for 8N1 framing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Cycles spent on one full frame for a given bit period.
    function automatic int frame_cycles(input int symbol_edge_time);
        return FRAME_BITS * symbol_edge_time;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter. Writes are synchronous and
// the head entry is always presented on data_o. Push is ignored when full
// and pop is ignored when empty, so the caller never corrupts the count.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               data_i,
    output logic [7:0]               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter. Bytes arrive over a valid/ready stream
// into a small FIFO and are serialised LSB first. While the FIFO holds
// data, the next start bit follows the previous stop bit with no gap.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (line low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high); chains into START if more data is queued
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [7:0]                    data_in_i,
    input  logic                          data_in_valid_i,
    output logic                          data_in_ready_o,
    output logic                          serial_out_o,
    output logic                          tx_busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int BAUD_W           = $clog2(SYMBOL_EDGE_TIME);
    localparam int BIT_W            = $clog2(DATA_BITS);
    localparam int CNT_W            = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    uart_tx_state_t    state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [BIT_W-1:0]  bit_q;
    logic [7:0]        shift_q;
    logic              serial_q;

    logic [7:0]        fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              push;
    logic              pop;
    logic              baud_done;

    assign push      = data_in_valid_i && !fifo_full;
    assign baud_done = (baud_q == BAUD_LAST);
    // Pop from IDLE, or on the last stop-bit cycle to chain frames back to back.
    assign pop       = !fifo_empty &&
                       ((state_q == IDLE) || ((state_q == STOP) && baud_done));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (data_in_i),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign data_in_ready_o = !fifo_full;
    assign fifo_count_o    = fifo_count;
    assign serial_out_o    = serial_q;
    assign tx_busy_o       = (state_q != IDLE) || (fifo_count != '0);

    // Frame sequencer: baud timing, bit counting, shifting and the registered line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    serial_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q  <= fifo_rdata;
                        baud_q   <= '0;
                        bit_q    <= '0;
                        serial_q <= 1'b0;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_q   <= '0;
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        state_q  <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            serial_q <= 1'b1;
                            state_q  <= STOP;
                        end else begin
                            bit_q    <= bit_q + BIT_W'(1);
                            serial_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (!fifo_empty) begin
                            shift_q  <= fifo_rdata;
                            bit_q    <= '0;
                            serial_q <= 1'b0;
                            state_q  <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    serial_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: a 10-cycles-per-bit instance for
// framing, chaining, back-pressure and reset, plus a default-rate
// instance for the bit-period measurement.
module tb_uart_tx_buffered;

    logic       clk;
    logic       rst;

    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       serial;
    logic       busy;
    logic [2:0] count;

    logic [7:0] d_data;
    logic       d_valid;
    logic       d_ready;
    logic       d_serial;
    logic       d_busy;
    logic [2:0] d_count;

    int checks   = 0;
    int failures = 0;

    uart_tx_buffered #(
        .CLOCK_FREQ (10),
        .BAUD_RATE  (1),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .data_in_i       (data),
        .data_in_valid_i (valid),
        .data_in_ready_o (ready),
        .serial_out_o    (serial),
        .tx_busy_o       (busy),
        .fifo_count_o    (count)
    );

    uart_tx_buffered u_dut_def (
        .clk_i           (clk),
        .rst_i           (rst),
        .data_in_i       (d_data),
        .data_in_valid_i (d_valid),
        .data_in_ready_o (d_ready),
        .serial_out_o    (d_serial),
        .tx_busy_o       (d_busy),
        .fifo_count_o    (d_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called on the first cycle of bit 'first'; checks the first and last
    // cycle of each remaining bit and returns one cycle past the stop bit.
    task automatic check_frame(input logic [7:0] b, input int first);
        logic exp;
        for (int k = first; k < 10; k++) begin
            if (k == 0)      exp = 1'b0;
            else if (k == 9) exp = 1'b1;
            else             exp = b[k-1];
            chk($sformatf("frame_%02h_bit%0d_first", b, k), 32'(serial), 32'(exp));
            step(9);
            chk($sformatf("frame_%02h_bit%0d_last", b, k), 32'(serial), 32'(exp));
            step(1);
        end
    endtask

    initial begin
        int  n;
        logic saw_low;

        rst     = 1'b1;
        data    = 8'h00;
        valid   = 1'b0;
        d_data  = 8'h00;
        d_valid = 1'b0;

        // Reset state
        step(2);
        chk("rst_serial", 32'(serial), 32'd1);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_count",  32'(count),  32'd0);
        chk("rst_ready",  32'(ready),  32'd1);
        rst = 1'b0;
        step(2);

        // Single byte 0x55
        data  = 8'h55;
        valid = 1'b1;
        step(1);
        valid = 1'b0;
        chk("single_count_E",  32'(count),  32'd1);
        chk("single_serial_E", 32'(serial), 32'd1);
        chk("single_busy_E",   32'(busy),   32'd1);
        step(1);
        chk("single_count_E1", 32'(count), 32'd0);
        check_frame(8'h55, 0);
        chk("single_busy_after",   32'(busy),   32'd0);
        chk("single_serial_after", 32'(serial), 32'd1);
        step(5);

        // Two bytes on consecutive cycles, chained frames
        data  = 8'hA5;
        valid = 1'b1;
        step(1);
        data  = 8'h3C;
        step(1);
        valid = 1'b0;
        chk("b2b_count", 32'(count), 32'd1);
        check_frame(8'hA5, 0);
        check_frame(8'h3C, 0);
        chk("b2b_busy_after",   32'(busy),   32'd0);
        chk("b2b_serial_after", 32'(serial), 32'd1);
        step(5);

        // Back-pressure: one byte in flight, then five more with valid held
        data  = 8'h11;
        valid = 1'b1;
        step(1);
        data  = 8'h22;
        step(1);
        chk("bp_start_low", 32'(serial), 32'd0);
        chk("bp_count_E1",  32'(count),  32'd1);
        data = 8'h33;
        step(1);
        data = 8'h44;
        step(1);
        data = 8'h55;
        step(1);
        chk("bp_count_full", 32'(count), 32'd4);
        chk("bp_ready_full", 32'(ready), 32'd0);
        data = 8'h66;
        step(96);
        chk("bp_stop_serial",  32'(serial), 32'd1);
        chk("bp_ready_before", 32'(ready),  32'd0);
        chk("bp_count_before", 32'(count),  32'd4);
        step(1);
        chk("bp_pop_serial", 32'(serial), 32'd0);
        chk("bp_pop_count",  32'(count),  32'd3);
        chk("bp_pop_ready",  32'(ready),  32'd1);
        step(1);
        valid = 1'b0;
        chk("bp_refill_count", 32'(count), 32'd4);
        chk("bp_refill_ready", 32'(ready), 32'd0);
        step(8);
        chk("bp_22_start_last", 32'(serial), 32'd0);
        step(1);
        check_frame(8'h22, 1);
        check_frame(8'h33, 0);
        check_frame(8'h44, 0);
        check_frame(8'h55, 0);
        check_frame(8'h66, 0);
        chk("bp_busy_after", 32'(busy), 32'd0);
        step(5);

        // Reset mid-DATA of 0xFF with two bytes queued
        data  = 8'hFF;
        valid = 1'b1;
        step(1);
        data = 8'hAA;
        step(1);
        data = 8'hBB;
        step(1);
        valid = 1'b0;
        step(20);
        chk("rstmid_count_before", 32'(count), 32'd2);
        chk("rstmid_busy_before",  32'(busy),  32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_serial", 32'(serial), 32'd1);
        chk("rstmid_count",  32'(count),  32'd0);
        chk("rstmid_ready",  32'(ready),  32'd1);
        chk("rstmid_busy",   32'(busy),   32'd0);
        step(3);
        rst = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 150; i++) begin
            step(1);
            if (serial !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
        end
        chk("rstmid_no_frames", 32'(saw_low), 32'd0);
        chk("rstmid_count_end", 32'(count),   32'd0);

        // Default rate: 0x00 frame on the 125 MHz / 115200 instance
        d_data  = 8'h00;
        d_valid = 1'b1;
        step(1);
        d_valid = 1'b0;
        step(1);
        chk("def_start_low", 32'(d_serial), 32'd0);
        n = 0;
        while (d_serial === 1'b0 && n < 20000) begin
            step(1);
            n++;
        end
        chk("def_low_cycles", 32'(n), 32'd9765);
        n = 0;
        while (d_busy === 1'b1 && n < 5000) begin
            step(1);
            n++;
        end
        chk("def_stop_cycles", 32'(n), 32'd1085);
        chk("def_serial_idle", 32'(d_serial), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
